// File: rtl/radar_timing_gen.sv
// rtl/radar_timing_gen.sv - radar range/bearing/PRF timing generator
//
// Purpose: produces range code, bearing code, PRF sync pulse and sweep-type
// flags from single-cycle range and bearing enable strobes on one clock.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   range_tick   one-cycle range-rate enable
//   bear_tick    one-cycle bearing-increment enable
//   bear_sync    one-cycle bearing clear (wins over bear_tick)
//   mode         00 fixed A, 01 fixed B, 10 stagger, 11 halt
//   range        range code within the current sweep
//   bear         bearing code
//   synclk       PRF sync, high for the first SYNC_HI ticks of a sweep
//   sweep_start  one-cycle pulse at each sweep start
//   north        one-cycle pulse on bearing wrap
//   f1           current sweep was started in stagger mode
//   f2           current sweep is type B
module radar_timing_gen #(
    parameter int RANGE_W   = 10,
    parameter int BEAR_W    = 12,
    parameter int PERIOD_A  = 1000,
    parameter int PERIOD_B  = 800,
    parameter int SYNC_HI_A = 500,
    parameter int SYNC_HI_B = 400,
    parameter int CNT_A     = 32,
    parameter int CNT_B     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               range_tick,
    input  logic               bear_tick,
    input  logic               bear_sync,
    input  logic [1:0]         mode,
    output logic [RANGE_W-1:0] range,
    output logic [BEAR_W-1:0]  bear,
    output logic               synclk,
    output logic               sweep_start,
    output logic               north,
    output logic               f1,
    output logic               f2
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_A       = 2'b00;
    localparam logic [1:0] MODE_B       = 2'b01;
    localparam logic [1:0] MODE_STAGGER = 2'b10;
    localparam logic [1:0] MODE_HALT    = 2'b11;

    localparam logic [RANGE_W-1:0] LAST_A     = RANGE_W'(PERIOD_A - 1);
    localparam logic [RANGE_W-1:0] LAST_B     = RANGE_W'(PERIOD_B - 1);
    localparam logic [RANGE_W-1:0] SYNC_END_A = RANGE_W'(SYNC_HI_A - 1);
    localparam logic [RANGE_W-1:0] SYNC_END_B = RANGE_W'(SYNC_HI_B - 1);
    localparam logic [7:0]         STAG_LAST  = 8'(CNT_A + CNT_B - 1);
    localparam logic [8:0]         STAG_B_1ST = 9'(CNT_A);

    state_t              state_q, state_d;
    logic [RANGE_W-1:0]  range_q, range_d;
    logic [BEAR_W-1:0]   bear_q, bear_d;
    logic                synclk_q, synclk_d;
    logic                sweep_start_q, sweep_start_d;
    logic                north_q, north_d;
    logic                f1_q, f1_d;
    logic                f2_q, f2_d;
    logic [7:0]          stag_q, stag_d;

    logic                at_last;
    logic                at_sync_end;
    logic                start_sweep;
    logic                halt_sweep;
    logic                is_stagger;
    logic [7:0]          stag_idx;
    logic                new_f2;
    logic [7:0]          stag_next;

    // Period and sync width of the running sweep follow its latched type (f2),
    // so a mode change mid-sweep cannot disturb them.
    always_comb begin
        at_last     = (range_q == (f2_q ? LAST_B : LAST_A));
        at_sync_end = (range_q == (f2_q ? SYNC_END_B : SYNC_END_A));
        start_sweep = range_tick && (mode != MODE_HALT) &&
                      ((state_q == ST_IDLE) || at_last);
        halt_sweep  = range_tick && (state_q == ST_RUN) && at_last &&
                      (mode == MODE_HALT);
    end

    // Type of the sweep about to start. The stagger count only counts on from
    // a previous stagger sweep (f1); any other predecessor restarts it at 0.
    always_comb begin
        is_stagger = (mode == MODE_STAGGER);
        stag_idx   = f1_q ? stag_q : 8'd0;
        stag_next  = (stag_idx == STAG_LAST) ? 8'd0 : stag_idx + 8'd1;
        if (is_stagger) begin
            new_f2 = ({1'b0, stag_idx} >= STAG_B_1ST);
        end else begin
            new_f2 = (mode == MODE_B);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_sweep) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_sweep) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        range_d       = range_q;
        synclk_d      = synclk_q;
        sweep_start_d = 1'b0;
        f1_d          = f1_q;
        f2_d          = f2_q;
        stag_d        = stag_q;
        bear_d        = bear_q;
        north_d       = 1'b0;

        if (start_sweep) begin
            range_d       = '0;
            synclk_d      = 1'b1;
            sweep_start_d = 1'b1;
            f1_d          = is_stagger;
            f2_d          = new_f2;
            stag_d        = is_stagger ? stag_next : 8'd0;
        end else if (halt_sweep) begin
            range_d  = '0;
            synclk_d = 1'b0;
            f1_d     = 1'b0;
            f2_d     = 1'b0;
            stag_d   = 8'd0;
        end else if (range_tick && (state_q == ST_RUN)) begin
            range_d = range_q + 1'b1;
            if (at_sync_end) begin
                synclk_d = 1'b0;
            end
        end

        if (bear_sync) begin
            bear_d = '0;
        end else if (bear_tick) begin
            bear_d = bear_q + 1'b1;
            if (bear_q == '1) begin
                north_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            range_q       <= '0;
            bear_q        <= '0;
            synclk_q      <= 1'b0;
            sweep_start_q <= 1'b0;
            north_q       <= 1'b0;
            f1_q          <= 1'b0;
            f2_q          <= 1'b0;
            stag_q        <= 8'd0;
        end else begin
            range_q       <= range_d;
            bear_q        <= bear_d;
            synclk_q      <= synclk_d;
            sweep_start_q <= sweep_start_d;
            north_q       <= north_d;
            f1_q          <= f1_d;
            f2_q          <= f2_d;
            stag_q        <= stag_d;
        end
    end

    assign range       = range_q;
    assign bear        = bear_q;
    assign synclk      = synclk_q;
    assign sweep_start = sweep_start_q;
    assign north       = north_q;
    assign f1          = f1_q;
    assign f2          = f2_q;

endmodule
